// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-bundle layout and per-stage payload widths.
package pipe_pkg;

  localparam int CTRL_W = 5;

  localparam int MEMWRITE = 0;
  localparam int MEMREAD  = 1;
  localparam int BRANCH   = 2;
  localparam int REGWRITE = 3;
  localparam int MEMTOREG = 4;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 256;
  localparam int EX_MEM_W = 128;
  localparam int MEM_WB_W = 96;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic branch;
    logic memread;
    logic memwrite;
  } ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage link carrying payload, pc and control bundle.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 256,
  parameter int PC_W      = 32,
  parameter int CTRL_W    = pipe_pkg::CTRL_W
);
  logic                 valid;
  logic                 ready;
  logic [PAYLOAD_W-1:0] payload;
  logic [PC_W-1:0]      pc;
  logic [CTRL_W-1:0]    ctrl;

  modport master (
    output valid,
    output payload,
    output pc,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  payload,
    input  pc,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_entry.sv
// One valid-tagged register slice; clear wins over load.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         v_o,
  output logic [W-1:0] q_o
);
  logic         v_q;
  logic         v_d;
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (clr_i) begin
      v_d = 1'b0;
    end else if (ld_i) begin
      v_d = 1'b1;
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      q_q <= '0;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign v_o = v_q;
  assign q_o = q_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: main entry plus optional skid entry, with flush.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 256,
  parameter int PC_W      = 32,
  parameter int CTRL_W    = pipe_pkg::CTRL_W,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_reg_if.slave       in_s,
  pipe_stage_reg_if.master      out_m,
  output logic [1:0]            occupancy
);
  localparam int EW = PAYLOAD_W + PC_W + CTRL_W;

  logic [EW-1:0] in_d;
  logic [EW-1:0] main_d;
  logic [EW-1:0] main_q;
  logic [EW-1:0] skid_q;
  logic          main_v;
  logic          skid_v;
  logic          in_rdy;
  logic          acc;
  logic          rel;
  logic          main_ld;
  logic          main_clr;

  assign in_d = {in_s.payload, in_s.pc, in_s.ctrl};
  assign acc  = in_s.valid && in_rdy && !flush;
  assign rel  = main_v && out_m.ready;

  generate
    if (SKID_EN) begin : g_skid
      logic skid_ld;
      logic skid_clr;

      // in_ready comes straight from a flop: no path from out_ready
      assign in_rdy   = !skid_v;
      assign main_ld  = !flush &&
                        ((!main_v && acc) || (rel && (skid_v || acc)));
      assign main_clr = flush || (rel && !skid_v && !acc);
      assign skid_ld  = !flush && main_v && !rel && acc;
      assign skid_clr = flush || (rel && skid_v);

      pipe_entry #(.W(EW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .ld_i  (skid_ld),
        .clr_i (skid_clr),
        .d_i   (in_d),
        .v_o   (skid_v),
        .q_o   (skid_q)
      );
    end else begin : g_single
      assign in_rdy   = !main_v || out_m.ready;
      assign main_ld  = acc;
      assign main_clr = flush || (rel && !acc);
      assign skid_v   = 1'b0;
      assign skid_q   = '0;
    end
  endgenerate

  // Skid always holds the older entry, so it refills main first
  assign main_d = skid_v ? skid_q : in_d;

  pipe_entry #(.W(EW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (main_ld),
    .clr_i (main_clr),
    .d_i   (main_d),
    .v_o   (main_v),
    .q_o   (main_q)
  );

  assign in_s.ready    = in_rdy;
  assign out_m.valid   = main_v;
  assign out_m.payload = main_q[EW-1 -: PAYLOAD_W];
  assign out_m.pc      = main_q[CTRL_W +: PC_W];
  assign out_m.ctrl    = main_v ? main_q[CTRL_W-1:0] : '0;
  assign occupancy     = {1'b0, main_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: queue model of a 2-deep (skid) and 1-deep (no skid) FIFO stage.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush_a;
  logic       flush_b;
  logic [1:0] occ_a;
  logic [1:0] occ_b;

  pipe_stage_reg_if #(.PAYLOAD_W(256), .PC_W(32), .CTRL_W(5)) a_in ();
  pipe_stage_reg_if #(.PAYLOAD_W(256), .PC_W(32), .CTRL_W(5)) a_out ();
  pipe_stage_reg_if #(.PAYLOAD_W(32), .PC_W(32), .CTRL_W(5)) b_in ();
  pipe_stage_reg_if #(.PAYLOAD_W(32), .PC_W(32), .CTRL_W(5)) b_out ();

  pipe_stage_reg #(
    .PAYLOAD_W(256), .PC_W(32), .CTRL_W(5), .SKID_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_s(a_in.slave), .out_m(a_out.master), .occupancy(occ_a)
  );

  pipe_stage_reg #(
    .PAYLOAD_W(32), .PC_W(32), .CTRL_W(5), .SKID_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_s(b_in.slave), .out_m(b_out.master), .occupancy(occ_b)
  );

  typedef struct {
    logic [255:0] p;
    logic [31:0]  pc;
    logic [4:0]   c;
  } ent_t;

  ent_t         qa[$];
  ent_t         qb[$];
  ent_t         last_a;
  ent_t         last_b;
  ent_t         e;
  logic [255:0] ga[$];
  int           errors;
  int           checks;
  int           b_seq;
  int           b_exp;
  bit           chk_on;
  bit           aa_seen;

  logic         sa_valid;
  logic         sa_ready;
  logic [1:0]   sa_occ;
  logic [255:0] sa_pay;
  logic [31:0]  sa_pc;
  logic [4:0]   sa_ctrl;

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_a(input bit v, input int k, input bit rdy);
    a_in.valid   = v;
    a_in.payload = 256'(k);
    a_in.pc      = 32'h1000 + 32'(k * 4);
    a_in.ctrl    = k[4:0];
    a_out.ready  = rdy;
  endtask

  task automatic cycle();
    bit   rel;
    bit   acc;
    ent_t h;
    b_in.valid   = 1'($urandom_range(0, 1));
    b_out.ready  = 1'($urandom_range(0, 1));
    b_in.payload = 32'(b_seq);
    b_in.pc      = 32'h2000 + 32'(b_seq);
    b_in.ctrl    = b_seq[4:0];
    @(negedge clk);
    sa_valid = a_out.valid;
    sa_ready = a_in.ready;
    sa_occ   = occ_a;
    sa_pay   = a_out.payload;
    sa_pc    = a_out.pc;
    sa_ctrl  = a_out.ctrl;
    if (chk_on) begin
      h = (qa.size() > 0) ? qa[0] : last_a;
      chk("a_valid", sa_valid, qa.size() > 0);
      chk("a_in_ready", sa_ready, qa.size() < 2);
      chk("a_occ", sa_occ, qa.size());
      chk("a_payload", sa_pay, h.p);
      chk("a_pc", sa_pc, h.pc);
      chk("a_ctrl", sa_ctrl, (qa.size() > 0) ? h.c : 5'd0);
      h = (qb.size() > 0) ? qb[0] : last_b;
      chk("b_valid", b_out.valid, qb.size() > 0);
      chk("b_in_ready", b_in.ready, qb.size() == 0 || b_out.ready);
      chk("b_occ", occ_b, qb.size());
      chk("b_payload", b_out.payload, h.p);
      chk("b_pc", b_out.pc, h.pc);
      chk("b_ctrl", b_out.ctrl, (qb.size() > 0) ? h.c : 5'd0);
      if (b_out.valid && b_out.ready) begin
        chk("b_order", b_out.payload, 256'(b_exp));
        b_exp++;
      end
    end
    if (sa_valid && a_out.ready) ga.push_back(sa_pay);
    if (sa_valid && sa_pay == 256'hAA) aa_seen = 1'b1;
    @(posedge clk);
    if (qa.size() > 0) last_a = qa[0];
    if (rst) begin
      qa.delete();
      last_a = '{p: '0, pc: '0, c: '0};
    end else if (flush_a) begin
      qa.delete();
    end else begin
      rel = qa.size() > 0 && a_out.ready;
      acc = a_in.valid && qa.size() < 2;
      if (rel) void'(qa.pop_front());
      if (acc) begin
        e = '{p: a_in.payload, pc: a_in.pc, c: a_in.ctrl};
        qa.push_back(e);
      end
    end
    if (qa.size() > 0) last_a = qa[0];
    if (qb.size() > 0) last_b = qb[0];
    if (rst) begin
      qb.delete();
      last_b = '{p: '0, pc: '0, c: '0};
      b_exp  = b_seq;
    end else begin
      rel = qb.size() > 0 && b_out.ready;
      acc = b_in.valid && (qb.size() == 0 || b_out.ready);
      if (rel) void'(qb.pop_front());
      if (acc) begin
        e = '{p: 256'(b_in.payload), pc: b_in.pc, c: b_in.ctrl};
        qb.push_back(e);
        b_seq++;
      end
    end
    if (qb.size() > 0) last_b = qb[0];
    #1;
  endtask

  task automatic chk_order(input string name);
    chk({name, "_count"}, 256'(ga.size()), 256'd8);
    for (int i = 0; i < ga.size() && i < 8; i++)
      chk(name, ga[i], 256'(i + 1));
  endtask

  initial begin
    int  k;
    int  c;
    bit  rdy;
    bit  took;
    errors  = 0;
    checks  = 0;
    b_seq   = 0;
    b_exp   = 0;
    chk_on  = 1'b0;
    aa_seen = 1'b0;
    last_a  = '{p: '0, pc: '0, c: '0};
    last_b  = '{p: '0, pc: '0, c: '0};
    rst     = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    drive_a(1'b0, 0, 1'b0);
    #1;
    cycle();
    chk_on = 1'b1;
    cycle();
    chk("rst_valid", sa_valid, 1'b0);
    chk("rst_occ", sa_occ, 2'd0);
    chk("rst_ready", sa_ready, 1'b1);
    chk("rst_payload", sa_pay, '0);

    rst = 1'b0;
    ga.delete();
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, i, 1'b1);
      cycle();
      if (i >= 2) begin
        chk("stream_occ", sa_occ, 2'd1);
        chk("stream_latency", sa_pay, 256'(i - 1));
      end
    end
    drive_a(1'b0, 0, 1'b1);
    repeat (3) cycle();
    chk_order("stream_order");

    ga.delete();
    k = 1;
    c = 0;
    while (k <= 8 && c < 40) begin
      rdy = !(c >= 3 && c <= 5);
      drive_a(1'b1, k, rdy);
      took = qa.size() < 2;
      cycle();
      if (c == 3) chk("bp_ready_lag", sa_ready, 1'b1);
      if (c == 4) begin
        chk("bp_ready_low", sa_ready, 1'b0);
        chk("bp_occ_full", sa_occ, 2'd2);
      end
      if (took) k++;
      c++;
    end
    chk("bp_all_accepted", 256'(k), 256'd9);
    drive_a(1'b0, 0, 1'b1);
    repeat (4) cycle();
    chk_order("bp_order");

    for (int i = 0; i < 4; i++) begin
      a_in.valid  = 1'b0;
      a_in.ctrl   = 5'h1F;
      a_out.ready = i[0];
      cycle();
      chk("bubble_ctrl", sa_ctrl, 5'd0);
      chk("bubble_valid", sa_valid, 1'b0);
    end

    drive_a(1'b1, 'h11, 1'b0);
    cycle();
    drive_a(1'b1, 'h22, 1'b0);
    cycle();
    flush_a = 1'b1;
    drive_a(1'b1, 'hAA, 1'b0);
    cycle();
    chk("flush_full", sa_occ, 2'd2);
    flush_a = 1'b0;
    drive_a(1'b0, 0, 1'b1);
    cycle();
    chk("flush_valid", sa_valid, 1'b0);
    chk("flush_occ", sa_occ, 2'd0);
    chk("flush_ready", sa_ready, 1'b1);
    chk("flush_hold", sa_pay, 256'h11);
    repeat (2) cycle();
    chk("flush_aa_seen", 256'(aa_seen), '0);

    drive_a(1'b1, 'h33, 1'b1);
    cycle();
    rst     = 1'b1;
    flush_a = 1'b1;
    drive_a(1'b1, 'h55, 1'b1);
    cycle();
    rst     = 1'b0;
    flush_a = 1'b0;
    drive_a(1'b0, 0, 1'b0);
    cycle();
    chk("rstfl_valid", sa_valid, 1'b0);
    chk("rstfl_occ", sa_occ, 2'd0);
    chk("rstfl_ready", sa_ready, 1'b1);
    chk("rstfl_payload", sa_pay, '0);
    chk("rstfl_pc", sa_pc, 32'd0);
    chk("rstfl_ctrl", sa_ctrl, 5'd0);

    drive_a(1'b0, 0, 1'b1);
    repeat (40) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) between stages of the RISC-V pipeline. It carries a data payload and a control bundle from one stage to the next with a valid/ready handshake, a two-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch mispredicts. Control outputs are forced to zero whenever the stage holds no valid entry, so downstream stages see a bubble, never stale write or memory enables.

## Interface
- PAYLOAD_W, default 256: payload width (e.g. ALU result, rd data, rs2, imm).
- PC_W, default 32: program-counter field width.
- CTRL_W, default 5: control bundle width (MemtoReg, RegWrite, Branch, MemRead, MemWrite).
- SKID_EN, default 1: 1 = two-entry skid buffer; 0 = single entry, with in_ready combinationally dependent on out_ready.

- clk  in  1  stage clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all held entries (synchronous).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_payload  in  PAYLOAD_W  upstream data.
- in_pc  in  PC_W  upstream PC / branch target.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the entry this cycle.
- out_payload  out  PAYLOAD_W  held data.
- out_pc  out  PC_W  held PC.
- out_ctrl  out  CTRL_W  held control; all zero when out_valid=0.
- occupancy  out  2  number of valid entries held (0..2; 0..1 if SKID_EN=0).

## Operation
- Entries: main (drives outputs) and skid (SKID_EN=1 only). Each entry has a valid bit plus payload, pc, and ctrl fields.
- Accept: in_valid && in_ready. Release: out_valid && out_ready.
- SKID_EN=1 state per cycle, with (main_v, skid_v) in {00, 10, 11}:
  - 00: accept → 10, main loads the input.
  - 10, release only → 00.
  - 10, accept only → 11, skid loads the input.
  - 10, accept and release → 10, main loads the input.
  - 10, neither → hold.
  - 11, release → 10, main loads from skid. No accept is possible in this state because in_ready=0.
  - 11, no release → hold.
- in_ready = !skid_v. It is registered and has no combinational path from out_ready.
- SKID_EN=0: in_ready = !main_v || out_ready. On accept, main loads the input.
- Entries leave in strict FIFO order. No entry is duplicated or lost except through flush.
- out_ctrl = main_ctrl when main_v, else 0. out_payload and out_pc hold their last value when invalid.
- Flush: the next state is empty (00). An input presented in the flush cycle is dropped even if in_ready=1. A release in the flush cycle still counts as a completed transfer downstream.
- Priority: rst > flush > accept/release.

## Timing
- Reset (synchronous): main_v=skid_v=0, every data field 0. Resulting outputs: out_valid=0, out_ctrl=0, out_payload=0, out_pc=0, occupancy=0, in_ready=1.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: one entry per cycle when out_ready is held high.
- Back-pressure: with SKID_EN=1, in_ready falls one cycle after out_ready falls. The entry accepted in that cycle lands in skid.
- Flush asserted in cycle N: out_valid=0 and in_ready=1 in cycle N+1.
- Reset asserted mid-transfer overrides everything. No entry survives it.

## Structure
- Shared package pipe_pkg holds:
  - the control-bundle field indices (MEMTOREG, REGWRITE, BRANCH, MEMREAD, MEMWRITE);
  - the CTRL_W constant;
  - per-stage payload width constants.
- Natural sub-module: pipe_entry. It is one valid-tagged register slice with load/clear enables and is instantiated as both main and skid.
- No memories and no clock gating.

## Test plan
- Reset then stream: rst high for 2 cycles, then in_valid=1 with payload 1..8 and out_ready=1. Required: outputs 1..8 on consecutive cycles, each one cycle after input, occupancy=1 throughout.
- Back-pressure: drop out_ready for 3 cycles while streaming. Required: in_ready=0 from the second cycle, occupancy=2, no loss or duplication; order 1..8 preserved after out_ready returns.
- Bubble control: in_ctrl=5'b11111 with in_valid=0. Required: out_ctrl=0 and out_valid=0 every cycle.
- Flush while full: occupancy=2, assert flush with in_valid=1 and payload 0xAA. Required: next cycle out_valid=0, occupancy=0, in_ready=1, and 0xAA never appears on the output.
- Reset versus flush and accept: assert rst, flush and in_valid together. Required: all outputs at reset values next cycle.
- SKID_EN=0 build: stream with random out_ready. Required: in_ready follows !main_v || out_ready in the same cycle and output order matches input.
